// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Holds default sizes and the index width / index legality functions.
package rf_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    // Index width for a file of n registers (never narrower than 1 bit).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // True when idx names a real, writable register.
    function automatic logic idx_writable(
        input int idx,
        input int nregs,
        input bit zero_reg
    );
        return (idx < nregs) && !(zero_reg && idx == 0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// A set and a clear aimed at the same register resolve to set.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    localparam int AW   = idx_width(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set_en,
    input  logic [AW-1:0]    set_idx,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_idx,
    output logic [NREGS-1:0] busy_vec,
    output logic [NREGS-1:0] busy_nxt
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_nxt;

    // Next scoreboard: apply the clear first so a same-index set overrides it.
    always_comb begin
        w_nxt = r_busy;
        for (int k = 0; k < NREGS; k++) begin
            if (clr_en && clr_idx == AW'(k)) begin
                w_nxt[k] = 1'b0;
            end
            if (set_en && set_idx == AW'(k)) begin
                w_nxt[k] = 1'b1;
            end
        end
    end

    // Scoreboard state, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_nxt;
        end
    end

    assign busy_vec = r_busy;
    assign busy_nxt = w_nxt;

endmodule

// File: rtl/rf_multiport.sv
// Multi-port register file with registered reads, write bypass
// and a pending-write scoreboard reported alongside each read.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = idx_width(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_idx,
    input  logic [XLEN-1:0]          wr_data,
    input  logic [NRD-1:0]           rd_en,
    input  logic [NRD-1:0][AW-1:0]   rd_idx,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_idx,
    output logic [NREGS-1:0]         busy_vec
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [XLEN-1:0]          r_regs [NREGS];
    logic [NRD-1:0][XLEN-1:0] r_rd_data;
    logic [NRD-1:0]           r_rd_busy;

    logic                     w_wr_ok;
    logic                     w_iss_ok;
    logic [NREGS-1:0]         w_busy_nxt;
    logic [NRD-1:0][XLEN-1:0] w_rd_val;
    logic [NRD-1:0]           w_rd_bsy;

    // Filter writes and issues that target x0 or a non-existent register.
    always_comb begin
        w_wr_ok  = wr_en  && idx_writable(int'(wr_idx),  NREGS, ZR);
        w_iss_ok = iss_en && idx_writable(int'(iss_idx), NREGS, ZR);
    end

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_en   (w_iss_ok),
        .set_idx  (iss_idx),
        .clr_en   (w_wr_ok),
        .clr_idx  (wr_idx),
        .busy_vec (busy_vec),
        .busy_nxt (w_busy_nxt)
    );

    // Per-port read mux with same-cycle write bypass; x0/out-of-range read 0.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            w_rd_val[p] = '0;
            w_rd_bsy[p] = 1'b0;
            if (idx_writable(int'(rd_idx[p]), NREGS, ZR)) begin
                for (int k = 0; k < NREGS; k++) begin
                    if (rd_idx[p] == AW'(k)) begin
                        w_rd_val[p] = r_regs[k];
                        w_rd_bsy[p] = w_busy_nxt[k];
                    end
                end
                if (w_wr_ok && wr_idx == rd_idx[p]) begin
                    w_rd_val[p] = wr_data;
                end
            end
        end
    end

    // Register storage as a plain flop array.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_wr_ok) begin
            for (int k = 0; k < NREGS; k++) begin
                if (wr_idx == AW'(k)) begin
                    r_regs[k] <= wr_data;
                end
            end
        end
    end

    // Read result registers: load when enabled, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_data <= '0;
            r_rd_busy <= '0;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                if (rd_en[p]) begin
                    r_rd_data[p] <= w_rd_val[p];
                    r_rd_busy[p] <= w_rd_bsy[p];
                end
            end
        end
    end

    assign rd_data = r_rd_data;
    assign rd_busy = r_rd_busy;

endmodule

// File: doc/rf_multiport.md
RF_MULTIPORT -- requirements
Module: rf_multiport

Interface
REQ-001 Parameter XLEN, default 32: register width in bits.
REQ-002 Parameter NREGS, default 32: number of architectural registers, 2..64.
REQ-003 Parameter NRD, default 2: number of read ports, 1..4.
REQ-004 Parameter ZERO_REG, default 1: 1 = register 0 hardwired to zero.
REQ-005 Local constant AW = clog2(NREGS): index width.
REQ-006 clk  in  1: single clock; all state changes on the rising edge.
REQ-007 reset_n  in  1: reset; synchronous and active-low.
REQ-008 wr_en  in  1: writeback request.
REQ-009 wr_idx  in  AW: writeback destination.
REQ-010 wr_data  in  XLEN: writeback value.
REQ-011 rd_en  in  NRD: per-port read enable.
REQ-012 rd_idx  in  NRD x AW: per-port source index.
REQ-013 rd_data  out  NRD x XLEN: per-port registered read value.
REQ-014 rd_busy  out  NRD: per-port registered pending-write flag.
REQ-015 iss_en  in  1: issue request; marks a destination as pending.
REQ-016 iss_idx  in  AW: issued destination index.
REQ-017 busy_vec  out  NREGS: current scoreboard, bit i = register i pending.

Function
REQ-018 Write: on an edge with wr_en=1, reg[wr_idx] <= wr_data.
REQ-019 Write ignored when wr_idx >= NREGS, or wr_idx = 0 with ZERO_REG=1.
REQ-020 Read latency: exactly 1 cycle; an edge with rd_en[i]=1 loads rd_data[i] and rd_busy[i].
REQ-021 Read hold: with rd_en[i]=0, rd_data[i] and rd_busy[i] hold their previous values indefinitely.
REQ-022 Read value: reg[rd_idx[i]], with bypass: if wr_en=1 in the same cycle, wr_idx = rd_idx[i], and the write is not ignored, rd_data[i] = wr_data.
REQ-023 Read of index 0 with ZERO_REG=1, or of index >= NREGS, returns 0 and rd_busy = 0.
REQ-024 All NRD ports are independent; any ports may read the same index in the same cycle with identical results.
REQ-025 Scoreboard set: iss_en=1 sets busy[iss_idx] on the edge; ignored for an index that REQ-019 would ignore.
REQ-026 Scoreboard clear: a non-ignored write clears busy[wr_idx] on the edge.
REQ-027 Simultaneous iss_en and wr_en on the same index: set wins, so busy = 1 and the register still takes wr_data.
REQ-028 rd_busy[i] equals the busy bit of rd_idx[i] as it is after the same edge's set/clear, i.e. consistent with the bypassed data.
REQ-029 Re-issue of an already-busy index keeps busy = 1; a write to a non-busy index is legal and leaves busy = 0.
REQ-030 busy_vec is a direct register output with no combinational path from the inputs.
REQ-031 busy_vec bit 0 is constant 0 when ZERO_REG=1.

Reset
REQ-032 On an edge with reset_n=0: all registers, busy_vec, rd_data and rd_busy go to 0.
REQ-033 Reset overrides any wr_en, iss_en or rd_en sampled on the same edge.
REQ-034 Operation resumes on the first edge with reset_n=1; reset asserted mid-operation discards all pending state.

Structure
REQ-035 The shared package rf_pkg holds the default XLEN and NREGS constants and the index-width helper function.
REQ-036 The scoreboard (busy_vec with set/clear priority) is a sub-module, rf_scoreboard.
REQ-037 Storage is a flop array, with no memory macro inference required.

Verification
REQ-038 Reset, then write 5 to x1, then read x1 on port 0: rd_data[0] = 5 one cycle after the read edge, rd_busy[0] = 0.
REQ-039 Same-cycle write x2 = 10 and read x2 on both ports: both rd_data = 10 after that edge (bypass).
REQ-040 Write 0xDEADBEEF to x0, then read x0: result 0; busy_vec[0] stays 0.
REQ-041 Issue x3, then read x3: rd_busy = 1; write x3 = 7 while reading x3 in the same cycle: rd_data = 7, rd_busy = 0, busy_vec[3] = 0.
REQ-042 iss_en and wr_en both target x4 with wr_data = 9: busy_vec[4] = 1 and a later read returns 9.
REQ-043 NREGS=24, NRD=4: write index 30 has no effect and reads of it return 0; assert reset_n=0 mid-sequence and all outputs read 0 on the next cycle.
